button_conditioner: RTL
=======================

# button_conditioner

Input-conditioning stage that sits directly upstream of the multiplier datapath. It takes the raw active-low push buttons and the 8-bit slide switches from the board pins, synchronizes them into the Clk domain, and debounces the buttons. It drives the clean `clear_a_load_b`, `run` and `S` signals the multiplier consumes, and adds single-cycle press pulses for downstream control.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 50000, number of consecutive stable cycles required before a button output changes (1 ms at 50 MHz); minimum 1
- SYNC_STAGES, 2, flip-flop depth of every synchronizer; minimum 2

Ports:
- Clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- clear_a_load_b_raw  in  1  raw button from pin, active-low, asynchronous and bouncy
- run_raw  in  1  raw button from pin, active-low, asynchronous and bouncy
- S_raw  in  8  raw slide switches from pins, asynchronous
- clear_a_load_b  out  1  conditioned button level, active-low, to multiplier
- run  out  1  conditioned button level, active-low, to multiplier
- S  out  8  synchronized switch value, to multiplier
- clear_pulse  out  1  one-cycle high pulse on each debounced press of clear_a_load_b
- run_pulse  out  1  one-cycle high pulse on each debounced press of run

## Operation

- Two identical, independent button channels. Each channel has a SYNC_STAGES-deep synchronizer, a stability counter and a 4-state FSM: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING.
- RELEASED -> PRESS_PENDING when the synced input is 0.
- PRESS_PENDING: the counter increments each cycle the synced input stays 0.
  - If the input returns to 1, go back to RELEASED and clear the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the input still 0, go to PRESSED. On that same edge the level output goes to 0, the pulse goes to 1, and the counter clears.
- PRESSED -> RELEASE_PENDING on synced input 1.
- RELEASE_PENDING follows the same rule mirrored:
  - Input returns to 0: back to PRESSED, counter cleared, no pulse.
  - Input held at 1 for DEBOUNCE_CYCLES cycles: go to RELEASED, level output goes to 1, no pulse.
- Pulse outputs are registered and high for exactly one cycle per press. Releases never pulse.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- S: each bit passes through a SYNC_STAGES-deep synchronizer with no debounce. Switch bounce settles far sooner than any debounced button press, so S is stable whenever the multiplier samples it.
- The two channels may press or release in the same cycle. Both pulses may assert together, and neither channel affects the other.
- Reset values:
  - Button synchronizer flops are 1 and S synchronizer flops are 0.
  - Both FSMs are in RELEASED with counters at 0.
  - clear_a_load_b=1, run=1, clear_pulse=0, run_pulse=0, S=8'h00.
- Asserting reset mid-operation, including in either pending state, forces the reset values immediately. No pulse is emitted. After reset releases, a button still held low goes through the full synchronize-and-debounce sequence.

## Timing

- Button latency, raw edge to level-output change: SYNC_STAGES + DEBOUNCE_CYCLES cycles, assuming a clean edge and ignoring synchronizer metastability. The pulse asserts on the same edge as the falling level output.
- Any raw glitch held for fewer than DEBOUNCE_CYCLES synced cycles produces no output change.
- S latency: SYNC_STAGES cycles.
- All outputs are driven directly from flops.

## Configuration

- Macro: BUTTON_DEBOUNCE_EN.
- Defined: behaviour exactly as above.
- Undefined: counters and pending states are compiled out. The FSM goes directly RELEASED <-> PRESSED on the synced value, which is equivalent to DEBOUNCE_CYCLES=1 and gives a latency of SYNC_STAGES+1 cycles. This is intended for fast simulation of the full multiplier; the pulse rule is unchanged.

## Structure

- Package button_conditioner_pkg holds:
  - the channel-state enum typedef (RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING);
  - the default constants DEBOUNCE_CYCLES_DEFAULT and SYNC_STAGES_DEFAULT.
- Sub-module debounce_channel holds one button's synchronizer, counter, FSM, level output and pulse output. It is instantiated twice.
- The S synchronizer lives in the top module.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, BUTTON_DEBOUNCE_EN defined.

- Reset: hold reset=0 with all raw inputs toggling -> clear_a_load_b=1, run=1, both pulses 0, S=8'h00 throughout.
- Clean press: run_raw falls and is held low 12 cycles -> run falls exactly 6 cycles after the raw edge; run_pulse is high for that one cycle only. Raw rises -> run rises 6 cycles later with no pulse.
- Bounce: run_raw low 3 cycles, high 1, low 2, then high -> run stays 1 and run_pulse stays 0.
- Simultaneous: both raw buttons fall on the same edge -> clear_a_load_b and run fall on the same cycle, 6 cycles later, with both pulses high together for one cycle.
- Switches: S_raw=8'hC5, then 8'h07 -> S shows 8'hC5 after 2 cycles, then 8'h07 2 cycles after that change.
- Reset mid-debounce: pulse reset low while run is PRESS_PENDING with run_raw held low -> run=1 and no pulse. run falls with a pulse 6 cycles after reset deasserts.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and defaults for the button/switch input conditioner.
// Latency: n/a (types and constants only). Backpressure: none.
// Feature macro: BUTTON_DEBOUNCE_EN (debounce counters in debounce_channel).
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } chan_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;
  localparam int SYNC_STAGES_DEFAULT     = 2;

endpackage

// File: rtl/debounce_channel.sv
// One active-low button: synchronizer, stability counter, 4-state FSM, level and press pulse.
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES (BUTTON_DEBOUNCE_EN) else SYNC_STAGES+1. Backpressure: none.
// Without BUTTON_DEBOUNCE_EN the counter and pending states are compiled out.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  if (DEBOUNCE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_param
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1 and SYNC_STAGES >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  chan_state_t            state;

  // Idle level of the button is high, so the chain resets to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef BUTTON_DEBOUNCE_EN
  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      level <= 1'b1;
      pulse <= 1'b0;
`ifdef BUTTON_DEBOUNCE_EN
      cnt   <= '0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
`ifdef BUTTON_DEBOUNCE_EN
        // cnt holds the number of consecutive stable cycles seen so far,
        // including the cycle that left the settled state.
        RELEASED: begin
          if (!synced) begin
            if (CNT_LAST == '0) begin
              state <= PRESSED;
              level <= 1'b0;
              pulse <= 1'b1;
            end else begin
              state <= PRESS_PENDING;
              cnt   <= CNT_ONE;
            end
          end
        end
        PRESS_PENDING: begin
          if (synced) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= PRESSED;
            level <= 1'b0;
            pulse <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (synced) begin
            if (CNT_LAST == '0) begin
              state <= RELEASED;
              level <= 1'b1;
            end else begin
              state <= RELEASE_PENDING;
              cnt   <= CNT_ONE;
            end
          end
        end
        RELEASE_PENDING: begin
          if (!synced) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= RELEASED;
            level <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RELEASED;
          level <= 1'b1;
          cnt   <= '0;
        end
`else
        RELEASED: begin
          if (!synced) begin
            state <= PRESSED;
            level <= 1'b0;
            pulse <= 1'b1;
          end
        end
        PRESSED: begin
          if (synced) begin
            state <= RELEASED;
            level <= 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          level <= 1'b1;
        end
`endif
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Board-pin conditioner: two debounced active-low buttons with press pulses, synced 8-bit switches.
// Latency: buttons per debounce_channel, S = SYNC_STAGES cycles. Backpressure: none.
// Feature macro: BUTTON_DEBOUNCE_EN (enables button debounce counters).
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       clear_a_load_b_raw,
  input  logic       run_raw,
  input  logic [7:0] S_raw,
  output logic       clear_a_load_b,
  output logic       run,
  output logic [7:0] S,
  output logic       clear_pulse,
  output logic       run_pulse
);

  logic [SYNC_STAGES-1:0][7:0] s_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_clear_chan (
    .clk     (Clk),
    .rst_n   (reset),
    .btn_raw (clear_a_load_b_raw),
    .level   (clear_a_load_b),
    .pulse   (clear_pulse)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_run_chan (
    .clk     (Clk),
    .rst_n   (reset),
    .btn_raw (run_raw),
    .level   (run),
    .pulse   (run_pulse)
  );

  // Switches settle long before any debounced press, so a plain synchronizer suffices.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) s_q <= '0;
    else        s_q <= {s_q[SYNC_STAGES-2:0], S_raw};
  end

  assign S = s_q[SYNC_STAGES-1];

endmodule
